// File: rtl/nn_ram_arbiter.sv
// Three-way arbiter for the shared activation RAM port: burst-held grants and a registered RAM control bus.
// Define NN_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (bit0 first).
module nn_ram_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int MAX_BURST = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        req,
  input  logic [2:0]        we,
  input  logic [2:0]        last,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  output logic [2:0]        gnt,
  output logic              en,
  output logic              r_w,
  output logic [ADDR_W-1:0] abus,
  output logic [1:0]        sel,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_id
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        win;
  logic              own_req, own_we, own_last;
  logic [ADDR_W-1:0] own_addr;
  logic              cnt_hit;
  logic              release_beat;

  // Owner's view of the request bus; sel is 3 when nobody owns the port.
  always_comb begin
    own_req  = 1'b0;
    own_we   = 1'b0;
    own_last = 1'b0;
    own_addr = '0;
    case (sel)
      2'd0: begin own_req = req[0]; own_we = we[0]; own_last = last[0]; own_addr = addr0; end
      2'd1: begin own_req = req[1]; own_we = we[1]; own_last = last[1]; own_addr = addr1; end
      2'd2: begin own_req = req[2]; own_we = we[2]; own_last = last[2]; own_addr = addr2; end
      default: ;
    endcase
  end

  assign cnt_hit      = (cnt == CNT_W'(MAX_BURST - 1));
  assign release_beat = (state == S_GRANT) && own_req && (own_last || cnt_hit);

`ifdef NN_ARB_RR_EN
  logic [1:0] ptr;

  always_comb begin
    logic found;
    int   idx;
    win   = 2'd0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < 3; i++) begin
      idx = (int'(ptr) + i) % 3;
      if (!found && req[idx]) begin
        win   = 2'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      ptr <= 2'd0;
    else if (release_beat)
      ptr <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
  end
`else
  always_comb begin
    if (req[0])      win = 2'd0;
    else if (req[1]) win = 2'd1;
    else             win = 2'd2;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      gnt    <= 3'b000;
      en     <= 1'b0;
      r_w    <= 1'b1;
      abus   <= '0;
      sel    <= 2'd3;
      busy   <= 1'b0;
      err    <= 1'b0;
      err_id <= 2'd0;
    end else begin
      en  <= 1'b0;
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            state <= S_GRANT;
            gnt   <= 3'b001 << win;
            sel   <= win;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        S_GRANT: begin
          if (own_req) begin
            en   <= 1'b1;
            abus <= own_addr;
            // Direction is fixed by the first beat of the burst.
            if (cnt == '0)
              r_w <= ~own_we;
            cnt <= cnt + CNT_W'(1);
            if (own_last || cnt_hit) begin
              state <= S_GAP;
              gnt   <= 3'b000;
              sel   <= 2'd3;
              busy  <= 1'b0;
              if (!own_last) begin
                err    <= 1'b1;
                err_id <= sel;
              end
            end
          end
        end
        S_GAP:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_ram_arbiter.sv
// Self-checking bench for nn_ram_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Compile with NN_ARB_RR_EN to check the round-robin build.
module tb_nn_ram_arbiter;
  localparam int AW = 16;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    req, we, last;
  logic [AW-1:0] addr0, addr1, addr2;
  logic [2:0]    gnt;
  logic          en, r_w, busy, err;
  logic [AW-1:0] abus;
  logic [1:0]    sel, err_id;

  int checks = 0;
  int failures = 0;

  nn_ram_arbiter #(.ADDR_W(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .last(last),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .gnt(gnt), .en(en), .r_w(r_w), .abus(abus), .sel(sel),
    .busy(busy), .err(err), .err_id(err_id)
  );

  always #5 clk = ~clk;

  // Behavioural model: who owns the port, whether we sit in the post-release gap, beats so far.
  int owner, beats, ptr, dir;
  bit in_gap;
  int e_gnt, e_en, e_rw, e_abus, e_sel, e_busy, e_err, e_err_id;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int pick_winner(input logic [2:0] r);
`ifdef NN_ARB_RR_EN
    for (int i = 0; i < 3; i++)
      if (r[(ptr + i) % 3]) return (ptr + i) % 3;
    return 0;
`else
    for (int i = 0; i < 3; i++)
      if (r[i]) return i;
    return 0;
`endif
  endfunction

  task automatic model_edge();
    int a[3];
    a[0] = addr0; a[1] = addr1; a[2] = addr2;
    e_err = 0;
    e_en  = 0;
    if (reset) begin
      owner = -1; in_gap = 0; beats = 0; ptr = 0;
      e_gnt = 0; e_rw = 1; e_abus = 0; e_sel = 3; e_busy = 0; e_err_id = 0;
    end else if (in_gap) begin
      in_gap = 0;
    end else if (owner < 0) begin
      if (req != 0) begin
        owner  = pick_winner(req);
        beats  = 0;
        e_gnt  = 1 << owner;
        e_sel  = owner;
        e_busy = 1;
      end
    end else if (req[owner]) begin
      if (beats == 0) dir = we[owner] ? 0 : 1;
      beats++;
      e_en   = 1;
      e_rw   = dir;
      e_abus = a[owner];
      if (last[owner] || beats == MB) begin
        if (!last[owner]) begin
          e_err = 1;
          e_err_id = owner;
        end
        ptr    = (owner + 1) % 3;
        owner  = -1;
        in_gap = 1;
        e_gnt = 0; e_sel = 3; e_busy = 0;
      end
    end
  endtask

  // One clock: model follows the edge, then every output is compared at the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("gnt", gnt, e_gnt);
    chk("en", en, e_en);
    if (e_en) begin
      chk("r_w", r_w, e_rw);
      chk("abus", abus, e_abus);
    end
    chk("sel", sel, e_sel);
    chk("busy", busy, e_busy);
    chk("err", err, e_err);
    chk("err_id", err_id, e_err_id);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 3'b000; last = 3'b000;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int exp_g[4];
    reset = 1'b1; req = 0; we = 0; last = 0; addr0 = 0; addr1 = 0; addr2 = 0;
    owner = -1; in_gap = 0; beats = 0; ptr = 0; dir = 1;
    @(negedge clk);
    do_reset();
    chk("reset_sel", sel, 3);
    chk("reset_rw", r_w, 1);
    chk("reset_gnt", gnt, 0);

    // Loader writes a three-beat burst at 0, 50, 100.
    req = 3'b010; we = 3'b010; addr1 = 0;
    step(); chk("t1_gnt", gnt, 3'b010);
    step(); chk("t1_en0", en, 1); chk("t1_rw0", r_w, 0); chk("t1_a0", abus, 0);
    addr1 = 50;
    step(); chk("t1_a1", abus, 50);
    addr1 = 100; last = 3'b010;
    step(); chk("t1_a2", abus, 100); chk("t1_busy", busy, 0);
    req = 0; last = 0;
    step(); chk("t1_gap_en", en, 0);
    step(); chk("t1_idle_busy", busy, 0);

    // Everyone requests, single-beat bursts.
`ifdef NN_ARB_RR_EN
    exp_g = '{1, 2, 4, 1};
`else
    exp_g = '{1, 1, 1, 1};
`endif
    do_reset();
    req = 3'b111; last = 3'b111; we = 3'b000;
    for (int b = 0; b < 4; b++) begin
      step(); chk("t2_gnt", gnt, exp_g[b]);
      step(); chk("t2_en", en, 1); chk("t2_rw", r_w, 1);
      step(); chk("t2_gap_gnt", gnt, 0);
    end

    // Compute owner drops req for two cycles mid-burst.
    do_reset();
    req = 3'b100; last = 0; we = 0; addr2 = 10;
    step(); chk("t3_gnt", gnt, 3'b100);
    step(); chk("t3_a0", abus, 10);
    addr2 = 11;
    step(); chk("t3_a1", abus, 11);
    req = 0;
    step(); chk("t3_bub1", en, 0); chk("t3_hold1", gnt, 3'b100);
    step(); chk("t3_bub2", en, 0); chk("t3_hold2", gnt, 3'b100);
    req = 3'b100; addr2 = 12; last = 3'b100;
    step(); chk("t3_a2", abus, 12); chk("t3_en", en, 1);
    req = 0; last = 0;
    step(); step();

    // Loader never asserts last: forced release after MB beats.
    do_reset();
    req = 3'b010; we = 3'b010;
    step();
    for (int b = 0; b < MB; b++) begin
      addr1 = AW'(200 + b);
      step(); chk("t4_en", en, 1); chk("t4_a", abus, 200 + b);
    end
    chk("t4_err", err, 1); chk("t4_err_id", err_id, 1); chk("t4_gnt", gnt, 0);
    step(); chk("t4_err_once", err, 0); chk("t4_gap_gnt", gnt, 0); chk("t4_err_hold", err_id, 1);
    step(); chk("t4_regrant", gnt, 3'b010);
    req = 0;
    step(); step(); step();

    // Reset lands on the second beat of a burst.
    do_reset();
    req = 3'b001; we = 3'b001; addr0 = 7;
    step(); step(); chk("t5_beat1", en, 1);
    addr0 = 8; reset = 1'b1;
    step(); chk("t5_rst_en", en, 0); chk("t5_rst_gnt", gnt, 0); chk("t5_rst_sel", sel, 3);
    chk("t5_rst_abus", abus, 0); chk("t5_rst_err", err, 0);
    reset = 1'b0; req = 0;
    step(); step(); chk("t5_quiet", en, 0);

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      req   = 3'($urandom);
      we    = 3'($urandom);
      last  = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      addr0 = AW'($urandom); addr1 = AW'($urandom); addr2 = AW'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nn_ram_arbiter.md
# nn_ram_arbiter

Arbitrates the shared 50-lane activation RAM port between three requesters:
- layer writeback;
- input/weight block loader;
- neuron compute reader.

The arbiter holds each grant for a full burst and drives the RAM control bus (enable, r_w, address) from registers. It also tells the data-side mux which requester owns the write data. It sits between the layer sequencer and the memory instance. It replaces hand-coded enable/r_w juggling in the sequencer.

## Interface
- ADDR_W, 16, RAM address width
- MAX_BURST, 32, maximum beats per grant before forced release (≥2)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req  in  3  per-requester request; bit0 writeback, bit1 loader, bit2 compute
- we  in  3  per-requester direction; 1 = write, 0 = read
- last  in  3  per-requester final-beat marker for current burst
- addr0, addr1, addr2  in  ADDR_W each  per-requester beat address
- gnt  out  3  one-hot grant; held for whole burst
- en  out  1  RAM enable for this cycle's beat
- r_w  out  1  RAM direction; 0 = write, 1 = read
- abus  out  ADDR_W  RAM address
- sel  out  2  owner index feeding the write-data mux; 3 = none
- busy  out  1  a grant is active
- err  out  1  one-cycle pulse on forced release
- err_id  out  2  requester that was force-released; held until next err

## Operation
- States:
  - IDLE: no owner.
  - GRANT: owner k holds the port.
  - GAP: one idle cycle after every release.
- IDLE → GRANT:
  - Taken when any req bit is high.
  - The winner is chosen by the arbitration policy (see Configuration).
  - gnt, sel and busy update at that edge.
- Beat acceptance:
  - A beat is accepted on any GRANT cycle with req[k]=1.
  - On the next edge the arbiter registers en=1, r_w=~we[k], abus=addrk.
  - If req[k]=0 during GRANT, the arbiter registers en=0 (bubble) and keeps the grant.
- Normal release: an accepted beat with last[k]=1 → GAP. gnt clears at the same edge as that beat's en/abus are registered.
- Beat counter:
  - Counts accepted beats; cleared on each new grant.
  - When an accepted beat makes the count equal MAX_BURST without last → forced release into GAP, with err=1 and err_id=k for one cycle.
  - The MAX_BURST-th beat is still issued.
- GAP → IDLE always. Requests seen in GAP are not granted until the IDLE cycle.
- Requester discipline: req, we and addr are ignored for non-owners. we[k] must be constant within a burst; only the first beat's we is honoured for r_w.
- Reset values:
  - gnt=0, en=0, r_w=1, abus=0, sel=3, busy=0, err=0, err_id=0.
  - State IDLE; beat counter 0; round-robin pointer at bit0.
- Reset mid-burst: the above values take effect at the next edge. The in-flight beat is dropped and no err is raised.

## Timing
- Request-to-grant latency: 1 cycle from IDLE.
- Grant-to-first-RAM-enable: 1 cycle (address registered).
- Minimum turnaround between bursts: 2 cycles (release edge, GAP, IDLE arbitration).
- Peak throughput within a burst: 1 beat/cycle.
- Single-beat burst (last on first beat): gnt is high for exactly one cycle and en is high for exactly one cycle, starting one cycle after gnt.
- Simultaneous last and MAX_BURST on the same beat counts as a normal release: no err.
- Beat counter width: clog2(MAX_BURST+1); it never wraps.

## Configuration
- NN_ARB_RR_EN defined: round-robin arbitration.
  - The priority pointer advances to the requester after the last owner on every release, normal or forced.
  - Search order is pointer, pointer+1, pointer+2 mod 3.
- NN_ARB_RR_EN undefined: fixed priority, bit0 > bit1 > bit2. The pointer logic is removed.

## Test plan
- Reset, then req=3'b010, we[1]=1, addr1=0,50,100, last on the third beat.
  - gnt=010 one cycle later.
  - en=1, r_w=0 on three consecutive cycles with abus 0, 50, 100.
  - busy falls after the third beat; 2 idle cycles follow.
- req=3'b111 held continuously, each burst 1 beat.
  - Fixed priority: grants go to 001 every burst.
  - With NN_ARB_RR_EN: grants rotate 001, 010, 100, 001.
- Compute owner drops req for 2 cycles mid-burst. en=0 for exactly those 2 cycles, gnt stays 100, and abus resumes with the next address.
- MAX_BURST=4, loader never asserts last.
  - Four beats are issued.
  - err pulses once, err_id=1, gnt clears.
  - The next grant comes after GAP.
- reset asserted on the second beat of a 5-beat burst. At the next edge all outputs take their reset values, and no further en occurs until a new request.
